// File: rtl/fan_pwm_array.sv
// Multi-channel fan PWM controller with Avalon-MM register access.
// Each channel ramps its duty toward a target by a bounded step at every period wrap.
module fan_pwm_array #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic            csi_MCLK_clk,
  input  logic            rsi_MRST_reset_n,
  input  logic [5:0]      avs_ctrl_address,
  input  logic            avs_ctrl_write,
  input  logic            avs_ctrl_read,
  input  logic [31:0]     avs_ctrl_writedata,
  input  logic [3:0]      avs_ctrl_byteenable,
  output logic [31:0]     avs_ctrl_readdata,
  output logic            avs_ctrl_waitrequest,
  output logic [N_CH-1:0] fan
);

  localparam logic [31:0] ID_VALUE = 32'hEA680004;

  function automatic logic [CNT_W-1:0] merge_cnt(input logic [CNT_W-1:0] old_v,
                                                 input logic [CNT_W-1:0] new_v,
                                                 input logic [CNT_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [31:0]            be_mask;
  logic                   wr_enable;
  logic                   wr_polarity;
  logic [N_CH-1:0]        enable_q;
  logic [N_CH-1:0]        enable_d;
  logic [N_CH-1:0]        polarity_q;
  logic [N_CH-1:0]        polarity_d;
  logic [N_CH-1:0][31:0]  ch_rd;
  logic [31:0]            rdata_d;
  logic [31:0]            readdata_q;
  logic                   unused_bits;

  assign be_mask = {{8{avs_ctrl_byteenable[3]}}, {8{avs_ctrl_byteenable[2]}},
                    {8{avs_ctrl_byteenable[1]}}, {8{avs_ctrl_byteenable[0]}}};
  assign unused_bits          = &{1'b0, avs_ctrl_writedata, be_mask};
  assign avs_ctrl_waitrequest = 1'b0;
  assign avs_ctrl_readdata    = readdata_q;

  assign wr_enable   = avs_ctrl_write && (avs_ctrl_address == 6'd1);
  assign wr_polarity = avs_ctrl_write && (avs_ctrl_address == 6'd2);
  assign enable_d    = (enable_q & ~be_mask[N_CH-1:0]) |
                       (avs_ctrl_writedata[N_CH-1:0] & be_mask[N_CH-1:0]);
  assign polarity_d  = (polarity_q & ~be_mask[N_CH-1:0]) |
                       (avs_ctrl_writedata[N_CH-1:0] & be_mask[N_CH-1:0]);

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      enable_q   <= '0;
      polarity_q <= '1;
      readdata_q <= '0;
    end else begin
      if (wr_enable)   enable_q   <= enable_d;
      if (wr_polarity) polarity_q <= polarity_d;
      // A write in the same cycle as a read suppresses the read.
      if (avs_ctrl_read && !avs_ctrl_write) readdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avs_ctrl_address)
      6'd0:    rdata_d = ID_VALUE;
      6'd1:    rdata_d = 32'(enable_q);
      6'd2:    rdata_d = 32'(polarity_q);
      default: ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (avs_ctrl_address[5:2] == 4'(c + 1)) rdata_d = ch_rd[c];
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             ch_sel;
    logic             wr_period;
    logic             wr_tgt;
    logic             wr_step;
    logic             wrap;
    logic             active;
    logic             fan_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] duty_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_act_q;

    assign ch_sel    = (avs_ctrl_address[5:2] == 4'(gi + 1));
    assign wr_period = avs_ctrl_write && ch_sel && (avs_ctrl_address[1:0] == 2'd0);
    assign wr_tgt    = avs_ctrl_write && ch_sel && (avs_ctrl_address[1:0] == 2'd1);
    assign wr_step   = avs_ctrl_write && ch_sel && (avs_ctrl_address[1:0] == 2'd2);
    assign wrap      = (per_act_q != '0) && (cnt_q == per_act_q - CNT_W'(1));
    assign active    = enable_q[gi] && (per_act_q != '0) && (cnt_q < duty_q);

    // Bounded approach toward the target; a zero step jumps straight to it.
    always_comb begin
      duty_d = duty_q;
      if (step_q == '0) begin
        duty_d = tgt_q;
      end else if (duty_q < tgt_q) begin
        duty_d = (tgt_q - duty_q > step_q) ? duty_q + step_q : tgt_q;
      end else if (duty_q > tgt_q) begin
        duty_d = (duty_q - tgt_q > step_q) ? duty_q - step_q : tgt_q;
      end
    end

    always_ff @(posedge csi_MCLK_clk) begin
      if (!rsi_MRST_reset_n) begin
        period_q  <= '0;
        tgt_q     <= '0;
        step_q    <= '0;
        duty_q    <= '0;
        cnt_q     <= '0;
        per_act_q <= '0;
        fan_q     <= 1'b1;
      end else begin
        if (wr_period) period_q <= merge_cnt(period_q, avs_ctrl_writedata[CNT_W-1:0], be_mask[CNT_W-1:0]);
        if (wr_tgt)    tgt_q    <= merge_cnt(tgt_q, avs_ctrl_writedata[CNT_W-1:0], be_mask[CNT_W-1:0]);
        if (wr_step)   step_q   <= merge_cnt(step_q, avs_ctrl_writedata[CNT_W-1:0], be_mask[CNT_W-1:0]);
        // A disabled channel parks per_act at 0, so enabling reloads PERIOD on the first cycle.
        if (!enable_q[gi]) begin
          cnt_q     <= '0;
          per_act_q <= '0;
          duty_q    <= '0;
        end else if (per_act_q == '0) begin
          cnt_q     <= '0;
          per_act_q <= period_q;
        end else if (wrap) begin
          cnt_q     <= '0;
          per_act_q <= period_q;
          duty_q    <= duty_d;
        end else begin
          cnt_q     <= cnt_q + CNT_W'(1);
        end
        fan_q <= active ^ polarity_q[gi];
      end
    end

    assign ch_rd[gi] = (avs_ctrl_address[1:0] == 2'd0) ? 32'(period_q) :
                       (avs_ctrl_address[1:0] == 2'd1) ? 32'(tgt_q)    :
                       (avs_ctrl_address[1:0] == 2'd2) ? 32'(step_q)   : 32'(duty_q);
    assign fan[gi] = fan_q;
  end

endmodule
